// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write-to-read bypass and a per-register
// busy scoreboard for tracking pending writebacks in the ID stage.
module regfile_mp #(
    parameter int unsigned DW       = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NR       = 2,
    parameter int unsigned NW       = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*DW-1:0] rd_data,
    output logic [NR-1:0]    rd_busy,
    input  logic [NW-1:0]    wr_en,
    input  logic [NW*AW-1:0] wr_addr,
    input  logic [NW*DW-1:0] wr_data,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             flush,
    output logic [AW:0]      busy_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Storage; later write ports overwrite earlier ones on an address clash
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                mem[AW'(r)] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NW; j++) begin
                if (wr_en[j] && !is_zero(wr_addr[j*AW +: AW])) begin
                    mem[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
                end
            end
        end
    end

    // Next busy vector: flush, then writeback clears, then issue sets (newest producer wins)
    always_comb begin
        busy_nxt = flush ? '0 : busy_q;
        if (!flush) begin
            for (int unsigned j = 0; j < NW; j++) begin
                if (wr_en[j]) begin
                    busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
                end
            end
        end
        if (iss_en && !is_zero(iss_addr)) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        cnt_nxt = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[AW'(r)]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= '0;
            busy_cnt <= '0;
        end else begin
            busy_q   <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Read ports: hard zero, else youngest matching write (never busy), else stored value
    always_comb begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          b;
        a       = '0;
        d       = '0;
        b       = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            a = rd_addr[k*AW +: AW];
            d = mem[a];
            b = busy_q[a];
            for (int unsigned j = 0; j < NW; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == a)) begin
                    d = wr_data[j*DW +: DW];
                    b = 1'b0;
                end
            end
            if (is_zero(a)) begin
                d = '0;
                b = 1'b0;
            end
            rd_data[k*DW +: DW] = d;
            rd_busy[k]          = b;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus randomized traffic against a
// per-register reference model, with NR=3 read and NW=2 write ports.
module tb_regfile_mp;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NR    = 3;
    localparam int unsigned NW    = 2;

    logic             clk;
    logic             rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic             flush;
    logic [AW:0]      busy_cnt;

    regfile_mp #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // stimulus in unpacked form
    int          r_addr [NR];
    bit          w_en   [NW];
    int          w_addr [NW];
    logic [31:0] w_data [NW];
    bit          m_iss;
    int          m_iss_addr;
    bit          m_flush;

    // reference state
    logic [31:0] m_mem  [DEPTH];
    bit          m_busy [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < int'(DEPTH); r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int r = 0; r < int'(DEPTH); r++) c += int'(m_busy[r]);
        return c;
    endfunction

    // expected read result for an address given the current stimulus
    task automatic ref_read(input int a, output logic [31:0] d, output logic b);
        if (a == 0) begin
            d = '0;
            b = 1'b0;
        end else begin
            d = m_mem[a];
            b = m_busy[a];
            for (int j = 0; j < int'(NW); j++) begin
                if (w_en[j] && w_addr[j] == a) begin
                    d = w_data[j];
                    b = 1'b0;
                end
            end
        end
    endtask

    task automatic idle();
        for (int j = 0; j < int'(NW); j++) begin
            w_en[j]   = 1'b0;
            w_addr[j] = 0;
            w_data[j] = '0;
        end
        m_iss      = 1'b0;
        m_iss_addr = 0;
        m_flush    = 1'b0;
    endtask

    task automatic pack();
        for (int k = 0; k < int'(NR); k++) rd_addr[k*AW +: AW] = AW'(r_addr[k]);
        for (int j = 0; j < int'(NW); j++) begin
            wr_en[j]             = w_en[j];
            wr_addr[j*AW +: AW]  = AW'(w_addr[j]);
            wr_data[j*DW +: DW]  = w_data[j];
        end
        iss_en   = m_iss;
        iss_addr = AW'(m_iss_addr);
        flush    = m_flush;
    endtask

    function automatic logic [31:0] rdp(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    // apply inputs and check combinational read outputs against the model
    task automatic settle();
        logic [31:0] d;
        logic        b;
        pack();
        #1;
        for (int k = 0; k < int'(NR); k++) begin
            ref_read(r_addr[k], d, b);
            check($sformatf("rd_data[%0d] a=%0d", k, r_addr[k]), rdp(k), d);
            check($sformatf("rd_busy[%0d] a=%0d", k, r_addr[k]), 32'(rd_busy[k]), 32'(b));
        end
    endtask

    // clock edge: advance the model per register, then check busy_cnt
    task automatic clock();
        bit hit;
        @(posedge clk);
        for (int r = 1; r < int'(DEPTH); r++) begin
            hit = 1'b0;
            for (int j = 0; j < int'(NW); j++) begin
                if (w_en[j] && w_addr[j] == r) begin
                    m_mem[r] = w_data[j];
                    hit      = 1'b1;
                end
            end
            if (m_iss && m_iss_addr == r) m_busy[r] = 1'b1;
            else if (m_flush)             m_busy[r] = 1'b0;
            else if (hit)                 m_busy[r] = 1'b0;
        end
        #1;
        check("busy_cnt", 32'(busy_cnt), 32'(model_cnt()));
    endtask

    task automatic set_rd_all(input int a);
        for (int k = 0; k < int'(NR); k++) r_addr[k] = a;
    endtask

    // async reset pulse between edges, with traffic held across an edge while in reset
    task automatic mid_reset();
        int a;
        idle();
        pack();
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            a = 1 + i * 5;
            set_rd_all(a);
            pack();
            #1;
            check("rst_async_data", rdp(0), 32'h0);
            check("rst_async_busy", 32'(rd_busy), 32'h0);
        end
        check("rst_async_cnt", 32'(busy_cnt), 32'h0);
        w_en[0] = 1'b1; w_addr[0] = 6; w_data[0] = 32'hA5A5_A5A5;
        m_iss = 1'b1; m_iss_addr = 7;
        pack();
        @(posedge clk);
        #1;
        idle();
        r_addr[0] = 6; r_addr[1] = 7; r_addr[2] = 0;
        pack();
        #1;
        check("rst_drop_wr", rdp(0), 32'h0);
        check("rst_drop_iss", 32'(rd_busy), 32'h0);
        check("rst_drop_cnt", 32'(busy_cnt), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < int'(NR); k++) r_addr[k] = 0;
        idle();
        model_reset();
        pack();

        // 1: reset state on every address
        for (int r = 0; r < int'(DEPTH); r++) begin
            set_rd_all(r);
            pack();
            #1;
            for (int k = 0; k < int'(NR); k++) begin
                check("reset_data", rdp(k), 32'h0);
                check("reset_busy", 32'(rd_busy[k]), 32'h0);
            end
        end
        check("reset_cnt", 32'(busy_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 2: write, read-back, bypass, register 0
        idle(); set_rd_all(5);
        w_en[0] = 1'b1; w_addr[0] = 5; w_data[0] = 32'hDEAD_BEEF;
        settle(); clock();
        idle(); settle();
        check("wr_readback", rdp(0), 32'hDEAD_BEEF);
        clock();
        w_en[0] = 1'b1; w_addr[0] = 5; w_data[0] = 32'h1234_5678;
        settle();
        check("bypass", rdp(1), 32'h1234_5678);
        clock();
        idle(); set_rd_all(0);
        w_en[0] = 1'b1; w_addr[0] = 0; w_data[0] = 32'hFFFF_FFFF;
        settle();
        check("r0_bypass", rdp(0), 32'h0);
        clock();
        idle(); settle();
        check("r0_stored", rdp(2), 32'h0);
        clock();

        // 3: two write ports to the same register
        idle(); set_rd_all(7);
        w_en[0] = 1'b1; w_addr[0] = 7; w_data[0] = 32'h11;
        w_en[1] = 1'b1; w_addr[1] = 7; w_data[1] = 32'h22;
        settle();
        check("conflict_bypass", rdp(0), 32'h22);
        clock();
        idle(); settle();
        check("conflict_stored", rdp(0), 32'h22);
        clock();

        // 4: scoreboard set, clear by writeback, issue beats writeback
        idle(); set_rd_all(9);
        m_iss = 1'b1; m_iss_addr = 9;
        settle(); clock();
        check("iss_cnt", 32'(busy_cnt), 32'd1);
        idle(); settle();
        check("iss_busy", 32'(rd_busy[0]), 32'd1);
        w_en[1] = 1'b1; w_addr[1] = 9; w_data[1] = 32'h55;
        pack(); #1;
        check("wb_busy", 32'(rd_busy[0]), 32'd0);
        check("wb_data", rdp(0), 32'h55);
        clock();
        check("wb_cnt", 32'(busy_cnt), 32'd0);
        idle();
        m_iss = 1'b1; m_iss_addr = 9;
        w_en[0] = 1'b1; w_addr[0] = 9; w_data[0] = 32'h66;
        settle(); clock();
        idle(); settle();
        check("iss_wins_busy", 32'(rd_busy[2]), 32'd1);
        check("iss_wins_cnt", 32'(busy_cnt), 32'd1);
        clock();

        // 5: flush with simultaneous issue
        idle(); m_flush = 1'b1; settle(); clock();
        for (int r = 1; r <= 3; r++) begin
            idle(); m_iss = 1'b1; m_iss_addr = r;
            settle(); clock();
        end
        check("three_busy", 32'(busy_cnt), 32'd3);
        idle(); m_flush = 1'b1; m_iss = 1'b1; m_iss_addr = 4;
        settle(); clock();
        check("flush_cnt", 32'(busy_cnt), 32'd1);
        idle(); r_addr[0] = 1; r_addr[1] = 3; r_addr[2] = 4;
        settle();
        check("flush_r1", 32'(rd_busy[0]), 32'd0);
        check("flush_r4", 32'(rd_busy[2]), 32'd1);
        clock();

        // 6: async reset mid-run, then randomized traffic
        mid_reset();
        for (int c = 0; c < 10000; c++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < int'(NR); k++)
                r_addr[k] = narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1));
            for (int j = 0; j < int'(NW); j++) begin
                w_en[j]   = ($urandom_range(0, 99) < 40);
                w_addr[j] = narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1));
                w_data[j] = $urandom;
            end
            m_iss      = ($urandom_range(0, 99) < 35);
            m_iss_addr = narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1));
            m_flush    = ($urandom_range(0, 99) < 3);
            settle();
            clock();
            if (c % 2500 == 1234) mid_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
